// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one debug UART transmitter among NREQ byte-stream
// requesters. The UART is granted round-robin, one whole packet at a time, and
// a watchdog frees the transmitter when the owner stalls mid-packet.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        uart_din,
  output logic              uart_wr_en,
  input  logic              uart_busy,
  output logic              timeout_pulse
);

  localparam int IDXW = $clog2(NREQ);
  localparam int WDW  = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    WAIT_TX = 2'd1,
    STROBE  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  // Returns ptr itself when nothing is valid; callers qualify with |valid.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx[IDXW-1:0]]) begin
        pick  = idx[IDXW-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // One-hot encoding of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = {NREQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Rotating-priority pointer value after owner finishes (modulo NREQ).
  function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] owner);
    logic [IDXW-1:0] nxt;
    if (owner == LAST_IDX) begin
      nxt = {IDXW{1'b0}};
    end else begin
      nxt = owner + 1'b1;
    end
    return nxt;
  endfunction

  // State and datapath registers
  state_t          state_r;
  logic [NREQ-1:0] grant_r;
  logic [IDXW-1:0] owner_r;
  logic [IDXW-1:0] rr_ptr_r;
  logic [WDW-1:0]  wd_r;
  logic            last_q_r;
  logic [7:0]      din_r;
  logic            wr_en_r;
  logic            timeout_r;

  // Next-state values
  state_t          state_s;
  logic [NREQ-1:0] grant_s;
  logic [IDXW-1:0] owner_s;
  logic [IDXW-1:0] rr_ptr_s;
  logic [WDW-1:0]  wd_s;
  logic            last_q_s;
  logic [7:0]      din_s;
  logic            wr_en_s;
  logic            timeout_s;

  // Helpers
  logic [IDXW-1:0] pick_s;
  logic            any_valid_s;
  logic            handshake_s;
  logic [7:0]      owner_data_s;

  // Only the owner may be ready, and only while the transmitter is idle, so a
  // post-reset byte naturally waits out a transmitter that was never reset.
  assign req_ready    = ((state_r == WAIT_TX) && !uart_busy) ? grant_r : {NREQ{1'b0}};
  assign pick_s       = rr_pick(req_valid, rr_ptr_r);
  assign any_valid_s  = |req_valid;
  assign handshake_s  = req_valid[owner_r] & req_ready[owner_r];
  assign owner_data_s = req_data[{owner_r, 3'b000} +: 8];

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    rr_ptr_s  = rr_ptr_r;
    wd_s      = wd_r;
    last_q_s  = last_q_r;
    din_s     = din_r;
    wr_en_s   = 1'b0;
    timeout_s = 1'b0;

    case (state_r)
      ARB: begin
        // req_last is deliberately ignored here; only valid starts a packet.
        if (any_valid_s) begin
          owner_s = pick_s;
          grant_s = onehot(pick_s);
          wd_s    = {WDW{1'b0}};
          state_s = WAIT_TX;
        end else begin
          grant_s = {NREQ{1'b0}};
          state_s = ARB;
        end
      end

      WAIT_TX: begin
        // An accepted byte takes priority over a watchdog expiry in the same cycle.
        if (handshake_s) begin
          din_s    = owner_data_s;
          wr_en_s  = 1'b1;
          last_q_s = req_last[owner_r];
          state_s  = STROBE;
        end else if (wd_r == WD_LIMIT) begin
          timeout_s = 1'b1;
          grant_s   = {NREQ{1'b0}};
          rr_ptr_s  = next_ptr(owner_r);
          state_s   = ARB;
        end else begin
          wd_s    = wd_r + 1'b1;
          state_s = WAIT_TX;
        end
      end

      STROBE: begin
        // The transmitter samples wr_en/din during this cycle; busy follows.
        state_s = DRAIN;
      end

      DRAIN: begin
        if (!uart_busy) begin
          if (last_q_r) begin
            grant_s  = {NREQ{1'b0}};
            rr_ptr_s = next_ptr(owner_r);
            state_s  = ARB;
          end else begin
            wd_s    = {WDW{1'b0}};
            state_s = WAIT_TX;
          end
        end else begin
          state_s = DRAIN;
        end
      end

      default: begin
        grant_s = {NREQ{1'b0}};
        state_s = ARB;
      end
    endcase
  end

  // Register all state and outputs; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ARB;
      grant_r   <= {NREQ{1'b0}};
      owner_r   <= {IDXW{1'b0}};
      rr_ptr_r  <= {IDXW{1'b0}};
      wd_r      <= {WDW{1'b0}};
      last_q_r  <= 1'b0;
      din_r     <= 8'h00;
      wr_en_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      rr_ptr_r  <= rr_ptr_s;
      wd_r      <= wd_s;
      last_q_r  <= last_q_s;
      din_r     <= din_s;
      wr_en_r   <= wr_en_s;
      timeout_r <= timeout_s;
    end
  end

  assign grant         = grant_r;
  assign uart_din      = din_r;
  assign uart_wr_en    = wr_en_r;
  assign timeout_pulse = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a packet-queue requester model
// and a simple transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  uart_din;
  logic        uart_wr_en;
  logic        uart_busy;
  logic        timeout_pulse;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .uart_din      (uart_din),
    .uart_wr_en    (uart_wr_en),
    .uart_busy     (uart_busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  // Requester model: per-requester byte list {last,data}, consumed on handshake
  logic [8:0] mem [4][32];
  int pos  [4] = '{0, 0, 0, 0};
  int endi [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i[1:0]] && req_ready[i[1:0]]) pos[i[1:0]] <= pos[i[1:0]] + 1;
    end
  end

  always_comb begin
    req_valid = 4'b0;
    req_data  = 32'h0;
    req_last  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i[1:0]] = (pos[i[1:0]] < endi[i[1:0]]);
      {req_last[i[1:0]], req_data[8*i +: 8]} = mem[i[1:0]][pos[i[1:0]][4:0]];
    end
  end

  // Transmitter model: busy for frame_len cycles starting the cycle after wr_en
  int   busy_cnt   = 0;
  int   frame_len  = 20;
  logic force_busy = 1'b0;

  always @(posedge clk) begin
    if (uart_wr_en) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0) || force_busy;

  // Strobe log
  logic [7:0] log_din [32];
  logic [3:0] log_gnt [32];
  int nlog = 0;

  always @(posedge clk) begin
    if (uart_wr_en && nlog < 32) begin
      log_din[nlog[4:0]] <= uart_din;
      log_gnt[nlog[4:0]] <= grant;
      nlog <= nlog + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    mem[r[1:0]][endi[r[1:0]][4:0]] = {l, d};
    endi[r[1:0]] = endi[r[1:0]] + 1;
  endtask

  task automatic wait_wr(input int budget, output int k);
    k = 0;
    while (!uart_wr_en && k < budget) begin
      tick();
      k++;
    end
    check("wr_en_within_budget", 32'(uart_wr_en), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((grant != 4'b0 || uart_busy) && k < 400) begin
      tick();
      k++;
    end
    check(tag, 32'({grant, uart_busy}), 32'd0);
  endtask

  task automatic wait_log(input string tag, input int target);
    int k;
    k = 0;
    while (nlog < target && k < 400) begin
      tick();
      k++;
    end
    check(tag, 32'(nlog), 32'(target));
  endtask

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int b;
    logic bad;

    for (int i = 0; i < 4; i++) begin
      endi[i[1:0]] = 0;
      for (int j = 0; j < 32; j++) mem[i[1:0]][j[4:0]] = 9'h0;
    end

    // Reset values
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_din", 32'(uart_din), 32'h0);
    check("rst_wr_en", 32'(uart_wr_en), 32'h0);
    check("rst_timeout", 32'(timeout_pulse), 32'h0);
    reset = 1'b0;

    // Single packet from requester 1: 0x48, 0x69(last), 20-cycle busy
    frame_len = 20;
    add_byte(1, 8'h48, 1'b0);
    add_byte(1, 8'h69, 1'b1);
    tick();
    check("t1_grant", 32'(grant), 32'h2);
    check("t1_ready", 32'(req_ready), 32'h2);
    tick();
    check("t1_wr_en1", 32'(uart_wr_en), 32'h1);
    check("t1_din1", 32'(uart_din), 32'h48);
    tick();
    check("t1_wr_en_one_cycle", 32'(uart_wr_en), 32'h0);
    wait_wr(60, k);
    check("t1_din2", 32'(uart_din), 32'h69);
    check("t1_strobe_spacing", 32'(k), 32'd22);
    k = 0;
    while (grant != 4'b0 && k < 60) begin
      tick();
      k++;
    end
    check("t1_release_delay", 32'(k), 32'd22);
    check("t1_grant_released", 32'(grant), 32'h0);

    // Round-robin contention: requesters 0 and 2, two-byte packets from reset
    reset = 1'b1;
    frame_len = 4;
    b = nlog;
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hB0, 1'b1);
    add_byte(2, 8'hA2, 1'b0);
    add_byte(2, 8'hB2, 1'b1);
    tick();
    reset = 1'b0;
    wait_log("t2_strobes", b + 4);
    check("t2_din0", 32'(log_din[b[4:0]]), 32'hA0);
    check("t2_din1", 32'(log_din[5'(b + 1)]), 32'hB0);
    check("t2_din2", 32'(log_din[5'(b + 2)]), 32'hA2);
    check("t2_din3", 32'(log_din[5'(b + 3)]), 32'hB2);
    check("t2_gnt1", 32'(log_gnt[5'(b + 1)]), 32'h1);
    check("t2_gnt2", 32'(log_gnt[5'(b + 2)]), 32'h4);
    wait_idle("t2_idle");

    // Fairness rotation: all four continuously valid with 1-byte packets
    reset = 1'b1;
    frame_len = 2;
    b = nlog;
    for (int i = 0; i < 4; i++) add_byte(i, 8'(16 + i), 1'b1);
    for (int i = 0; i < 4; i++) add_byte(i, 8'(32 + i), 1'b1);
    tick();
    reset = 1'b0;
    wait_log("t3_strobes", b + 8);
    check("t3_gnt0", 32'(log_gnt[b[4:0]]), 32'h1);
    check("t3_gnt1", 32'(log_gnt[5'(b + 1)]), 32'h2);
    check("t3_gnt2", 32'(log_gnt[5'(b + 2)]), 32'h4);
    check("t3_gnt3", 32'(log_gnt[5'(b + 3)]), 32'h8);
    check("t3_gnt4", 32'(log_gnt[5'(b + 4)]), 32'h1);
    check("t3_din4", 32'(log_din[5'(b + 4)]), 32'h20);
    wait_idle("t3_idle");

    // Timeout: requester 3 sends a non-last byte then stalls; requester 0 waits
    reset = 1'b1;
    frame_len = 4;
    add_byte(3, 8'h33, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("t4_grant3", 32'(grant), 32'h8);
    add_byte(0, 8'h0A, 1'b1);
    wait_wr(20, k);
    check("t4_din", 32'(uart_din), 32'h33);
    k = 0;
    while (req_ready != 4'b1000 && k < 20) begin
      tick();
      k++;
    end
    check("t4_rewait", 32'(req_ready), 32'h8);
    k = 0;
    while (!timeout_pulse && k < 40) begin
      tick();
      k++;
    end
    check("t4_timeout_delay", 32'(k), 32'd16);
    check("t4_timeout_high", 32'(timeout_pulse), 32'h1);
    check("t4_grant_cleared", 32'(grant), 32'h0);
    tick();
    check("t4_timeout_one_cycle", 32'(timeout_pulse), 32'h0);
    check("t4_next_grant", 32'(grant), 32'h1);
    wait_wr(20, k);
    check("t4_din0", 32'(uart_din), 32'h0A);
    wait_idle("t4_idle");

    // Busy honouring: transmitter held busy while requester 0 is valid
    frame_len = 4;
    force_busy = 1'b1;
    add_byte(0, 8'h55, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_ready != 4'b0 || uart_wr_en) bad = 1'b1;
    end
    check("t5_grant", 32'(grant), 32'h1);
    check("t5_blocked", 32'(bad), 32'h0);
    force_busy = 1'b0;
    #1;
    check("t5_ready_first_low", 32'(req_ready), 32'h1);
    tick();
    check("t5_wr_en", 32'(uart_wr_en), 32'h1);
    check("t5_din", 32'(uart_din), 32'h55);
    wait_idle("t5_idle");

    // Reset mid-packet during DRAIN; transmitter keeps running
    reset = 1'b1;
    frame_len = 14;
    add_byte(2, 8'h77, 1'b0);
    add_byte(2, 8'h78, 1'b1);
    tick();
    reset = 1'b0;
    wait_wr(20, k);
    check("t6_din1", 32'(uart_din), 32'h77);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    check("t6_rst_din", 32'(uart_din), 32'h0);
    check("t6_rst_wr_en", 32'(uart_wr_en), 32'h0);
    check("t6_rst_timeout", 32'(timeout_pulse), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    k = 0;
    bad = 1'b0;
    while (!uart_wr_en && k < 40) begin
      tick();
      k++;
      if (req_ready != 4'b0 && uart_busy) bad = 1'b1;
    end
    check("t6_post_reset_delay", 32'(k), 32'd11);
    check("t6_din2", 32'(uart_din), 32'h78);
    check("t6_grant", 32'(grant), 32'h4);
    check("t6_no_ready_while_busy", 32'(bad), 32'h0);
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
